// File: rtl/mem_seq_pkg.sv
// Shared definitions for the vector memory sequencer: default widths and
// the controller state encoding.
package mem_seq_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Element address generator: latches base/len at command start, counts the
// element index, forms base+idx (wrapping naturally at 2^ADDR_W) and flags
// the last element.
module mem_addr_gen
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_in,
   input  logic [ADDR_W-1:0] len_in,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] idx,
   output logic              last
);

   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   // Next-state: start reloads the command fields, advance steps the index.
   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      idx_d  = idx_q;
      if (start) begin
         base_d = base_in;
         len_d  = len_in;
         idx_d  = '0;
      end else if (advance) begin
         idx_d = idx_q + ADDR_W'(1);
      end
   end

   // Command field and index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end

   // Address is the modular sum; len==0 never reaches RUN so len-1 is safe.
   always_comb begin
      addr = base_q + idx_q;
      idx  = idx_q;
      last = (idx_q == (len_q - ADDR_W'(1)));
   end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Vector memory sequencer. Accepts one load/store command at a time and walks
// base..base+len-1 over a single-port RAM with one-cycle read latency.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// a store element transfers on a rising edge where wdata_valid && wdata_ready.
module mem_seq_ctrl
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_store,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              abort,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_q,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic [ADDR_W-1:0] rdata_idx,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state_dbg
);

   state_e            state_q, state_d;
   logic              store_q, store_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic [ADDR_W-1:0] rdata_idx_q, rdata_idx_d;

   logic              start;
   logic              wr_fire;
   logic              rd_issue;
   logic              advance;
   logic [ADDR_W-1:0] idx;
   logic              last;

   mem_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .base_in (cmd_base),
      .len_in  (cmd_len),
      .advance (advance),
      .addr    (mem_addr),
      .idx     (idx),
      .last    (last)
   );

   // Per-cycle datapath decisions and FSM next state.
   always_comb begin
      start    = (state_q == ST_IDLE) && cmd_valid;
      wr_fire  = (state_q == ST_RUN) && store_q && wdata_valid && !abort;
      rd_issue = (state_q == ST_RUN) && !store_q && !abort;
      advance  = wr_fire || rd_issue;

      store_d       = start ? cmd_store : store_q;
      rdata_valid_d = rd_issue;
      rdata_idx_d   = rd_issue ? idx : rdata_idx_q;

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) state_d = (cmd_len != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            if (abort)                  state_d = ST_IDLE;
            else if (wr_fire && last)   state_d = ST_DONE;
            else if (rd_issue && last)  state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM state, command direction and read-response pipeline stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         store_q       <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_idx_q   <= '0;
      end else begin
         state_q       <= state_d;
         store_q       <= store_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_idx_q   <= rdata_idx_d;
      end
   end

   // Output decode; rdata is forced to zero when not flagged valid.
   always_comb begin
      cmd_ready   = (state_q == ST_IDLE);
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE);
      mem_wren    = wr_fire;
      wdata_ready = wr_fire;
      mem_wdata   = wdata_in;
      rdata_valid = rdata_valid_q;
      rdata_idx   = rdata_idx_q;
      rdata       = rdata_valid_q ? mem_q : '0;
      state_dbg   = state_q;
   end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: directed commands against a behavioural RAM, with
// every write, load response and done pulse checked (including its cycle
// offset from command accept) by a scoreboard monitor.
module tb_mem_seq_ctrl;
   import mem_seq_pkg::*;

   localparam int EW = 58;   // {kind[1:0], key[7:0], data[31:0], offset[15:0]}
   localparam logic [1:0] K_WR = 2'd1;
   localparam logic [1:0] K_RD = 2'd2;
   localparam logic [1:0] K_DN = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_store;
   logic [7:0]  cmd_base, cmd_len;
   logic        abort;
   logic [31:0] wdata_in;
   logic        wdata_valid, wdata_ready;
   logic [7:0]  mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wdata, mem_q;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic [7:0]  rdata_idx;
   logic        busy, done;
   logic [1:0]  state_dbg;

   logic [31:0]   ram [256];
   logic [EW-1:0] exp_q [$];
   int            cyc = 0;
   int            acc_cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;

   mem_seq_ctrl dut (
      .clk (clk), .rst_n (rst_n),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_store (cmd_store),
      .cmd_base (cmd_base), .cmd_len (cmd_len), .abort (abort),
      .wdata_in (wdata_in), .wdata_valid (wdata_valid), .wdata_ready (wdata_ready),
      .mem_addr (mem_addr), .mem_wren (mem_wren), .mem_wdata (mem_wdata), .mem_q (mem_q),
      .rdata (rdata), .rdata_valid (rdata_valid), .rdata_idx (rdata_idx),
      .busy (busy), .done (done), .state_dbg (state_dbg)
   );

   // ---------------- clock / reset / RAM model ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int a = 0; a < 256; a++) ram[a] = 32'hA000_0000 | 32'(a);
   end

   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
   end

   // ---------------- helpers ----------------
   function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [7:0] key,
                                        input logic [31:0] d, input logic [15:0] off);
      return {k, key, d, off};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input logic [EW-1:0] act);
      logic [EW-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d key=%h data=%h off=%0d, expected none",
                  act[57:56], act[55:48], act[47:16], act[15:0]);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_err++;
            $display("FAIL event: got kind=%0d key=%h data=%h off=%0d, expected kind=%0d key=%h data=%h off=%0d",
                     act[57:56], act[55:48], act[47:16], act[15:0],
                     e[57:56], e[55:48], e[47:16], e[15:0]);
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   // Samples on the falling edge; events are ordered write, read, done.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_wren || wdata_ready) check("wdata_ready_eq_wren", {31'd0, wdata_ready}, {31'd0, mem_wren});
         if (mem_wren)    sb_pop(mk(K_WR, mem_addr, mem_wdata, 16'(cyc - acc_cyc)));
         if (rdata_valid) sb_pop(mk(K_RD, rdata_idx, rdata, 16'(cyc - acc_cyc)));
         if (done)        sb_pop(mk(K_DN, 8'h00, 32'h0, 16'(cyc - acc_cyc)));
      end
   end

   // ---------------- driver tasks ----------------
   // Offers a command just after a rising edge; returns one cycle after accept.
   task automatic do_cmd(input logic st, input logic [7:0] base, input logic [7:0] len);
      int budget;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_store = st; cmd_base = base; cmd_len = len;
      budget = 0;
      while (!cmd_ready && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!cmd_ready) begin
         n_cmp++; n_err++;
         $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1");
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: got %0d pending events, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_len = '0;
      abort = 1'b0; wdata_in = '0; wdata_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready",   {31'd0, cmd_ready},   32'd1);
      check("rst_busy",        {31'd0, busy},        32'd0);
      check("rst_done",        {31'd0, done},        32'd0);
      check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      check("rst_rdata",       rdata,                32'd0);
      check("rst_rdata_idx",   {24'd0, rdata_idx},   32'd0);
      check("rst_mem_addr",    {24'd0, mem_addr},    32'd0);
      check("rst_mem_wren",    {31'd0, mem_wren},    32'd0);
      check("rst_state",       {30'd0, state_dbg},   32'(ST_IDLE));
      rst_n = 1'b1;

      // Store base 0x10 len 4, data always valid.
      exp_q.push_back(mk(K_WR, 8'h10, 32'h1111_0000, 16'd1));
      exp_q.push_back(mk(K_WR, 8'h11, 32'h1111_0001, 16'd2));
      exp_q.push_back(mk(K_WR, 8'h12, 32'h1111_0002, 16'd3));
      exp_q.push_back(mk(K_WR, 8'h13, 32'h1111_0003, 16'd4));
      exp_q.push_back(mk(K_DN, 8'h00, 32'h0,         16'd5));
      wdata_valid = 1'b1; wdata_in = 32'h1111_0000;
      do_cmd(1'b1, 8'h10, 8'd4);
      check("st_busy", {31'd0, busy}, 32'd1);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); #1;
         wdata_in = 32'h1111_0000 + 32'(k);
      end
      @(posedge clk); #1;
      wdata_valid = 1'b0;
      wait_drain();

      // Load base 0xFE len 4, address wraps past 0xFF.
      exp_q.push_back(mk(K_RD, 8'd0, 32'hA000_00FE, 16'd2));
      exp_q.push_back(mk(K_RD, 8'd1, 32'hA000_00FF, 16'd3));
      exp_q.push_back(mk(K_RD, 8'd2, 32'hA000_0000, 16'd4));
      exp_q.push_back(mk(K_RD, 8'd3, 32'hA000_0001, 16'd5));
      exp_q.push_back(mk(K_DN, 8'h00, 32'h0,        16'd6));
      do_cmd(1'b0, 8'hFE, 8'd4);
      check("ld_addr0", {24'd0, mem_addr}, 32'h0000_00FE);
      check("ld_state_run", {30'd0, state_dbg}, 32'(ST_RUN));
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ld_addr_wrap", {24'd0, mem_addr}, 32'h0000_0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ld_state_drain", {30'd0, state_dbg}, 32'(ST_DRAIN));
      wait_drain();

      // Store base 0x20 len 3 with a two-cycle gap after element 0.
      exp_q.push_back(mk(K_WR, 8'h20, 32'h2222_0000, 16'd1));
      exp_q.push_back(mk(K_WR, 8'h21, 32'h2222_0001, 16'd4));
      exp_q.push_back(mk(K_WR, 8'h22, 32'h2222_0002, 16'd5));
      exp_q.push_back(mk(K_DN, 8'h00, 32'h0,         16'd6));
      wdata_valid = 1'b1; wdata_in = 32'h2222_0000;
      do_cmd(1'b1, 8'h20, 8'd3);
      @(posedge clk); #1;
      wdata_valid = 1'b0; wdata_in = 32'h2222_0001;
      check("gap_addr_a", {24'd0, mem_addr}, 32'h0000_0021);
      @(posedge clk); #1;
      check("gap_addr_b", {24'd0, mem_addr}, 32'h0000_0021);
      check("gap_wdata_ready", {31'd0, wdata_ready}, 32'd0);
      @(posedge clk); #1;
      wdata_valid = 1'b1;
      @(posedge clk); #1;
      wdata_in = 32'h2222_0002;
      @(posedge clk); #1;
      wdata_valid = 1'b0;
      wait_drain();

      // Zero-length command: done the cycle after accept, no RAM access.
      exp_q.push_back(mk(K_DN, 8'h00, 32'h0, 16'd1));
      wdata_valid = 1'b1; wdata_in = 32'hDEAD_BEEF;
      do_cmd(1'b1, 8'h30, 8'd0);
      check("len0_done", {31'd0, done}, 32'd1);
      wdata_valid = 1'b0;
      wait_drain();

      // Load base 0x40 len 8, abort on element 2.
      exp_q.push_back(mk(K_RD, 8'd0, 32'hA000_0040, 16'd2));
      exp_q.push_back(mk(K_RD, 8'd1, 32'hA000_0041, 16'd3));
      do_cmd(1'b0, 8'h40, 8'd8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      check("abort_addr", {24'd0, mem_addr}, 32'h0000_0042);
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_state_idle", {30'd0, state_dbg}, 32'(ST_IDLE));
      check("abort_busy", {31'd0, busy}, 32'd0);
      wait_drain();

      // Reset during store element 1.
      exp_q.push_back(mk(K_WR, 8'h80, 32'h3333_0000, 16'd1));
      wdata_valid = 1'b1; wdata_in = 32'h3333_0000;
      do_cmd(1'b1, 8'h80, 8'd3);
      @(posedge clk); #1;
      wdata_in = 32'h3333_0001;
      check("pre_rst_wren", {31'd0, mem_wren}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_wren",  {31'd0, mem_wren},  32'd0);
      check("rst_mid_state", {30'd0, state_dbg}, 32'(ST_IDLE));
      check("rst_mid_done",  {31'd0, done},      32'd0);
      wdata_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      wait_drain();

      // Normal store then load-back after the reset.
      exp_q.push_back(mk(K_WR, 8'h80, 32'h4444_0000, 16'd1));
      exp_q.push_back(mk(K_DN, 8'h00, 32'h0,         16'd2));
      wdata_valid = 1'b1; wdata_in = 32'h4444_0000;
      do_cmd(1'b1, 8'h80, 8'd1);
      @(posedge clk); #1;
      wdata_valid = 1'b0;
      wait_drain();

      exp_q.push_back(mk(K_RD, 8'd0, 32'h4444_0000, 16'd2));
      exp_q.push_back(mk(K_RD, 8'd1, 32'hA000_0081, 16'd3));
      exp_q.push_back(mk(K_RD, 8'd2, 32'hA000_0082, 16'd4));
      exp_q.push_back(mk(K_DN, 8'h00, 32'h0,        16'd5));
      do_cmd(1'b0, 8'h80, 8'd3);
      wait_drain();

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  vector memory command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-007 cmd_store  in  1  1 = store, 0 = load; sampled at accept.
REQ-008 cmd_base  in  ADDR_W  first element address; sampled at accept.
REQ-009 cmd_len  in  ADDR_W  element count; 0 = no-op; sampled at accept.
REQ-010 abort  in  1  terminate the active command.
REQ-011 wdata_in  in  DATA_W  store element from the pipeline.
REQ-012 wdata_valid  in  1  wdata_in holds a valid element.
REQ-013 wdata_ready  out  1  current store element consumed this cycle.
REQ-014 mem_addr  out  ADDR_W  RAM address.
REQ-015 mem_wren  out  1  RAM write enable.
REQ-016 mem_wdata  out  DATA_W  RAM write data.
REQ-017 mem_q  in  DATA_W  RAM read data, valid one cycle after address.
REQ-018 rdata  out  DATA_W  loaded element to write-back.
REQ-019 rdata_valid  out  1  rdata/rdata_idx valid.
REQ-020 rdata_idx  out  ADDR_W  element index of rdata.
REQ-021 busy  out  1  high in any state except IDLE.
REQ-022 done  out  1  one-cycle completion pulse.

Function
REQ-023 FSM states IDLE, RUN, DRAIN, DONE, encoded in 2 bits.
REQ-024 IDLE: cmd_ready=1; on accept with cmd_len!=0 -> RUN, idx<=0, latch store/base/len; with cmd_len==0 -> DONE; cmd_ready=0 in all other states.
REQ-025 mem_addr = (base + idx) mod 2^ADDR_W, combinational from registered base/idx; wrap past 255 to 0 without error.
REQ-026 RUN store: mem_wren = wdata_valid && !abort, mem_wdata = wdata_in, wdata_ready = mem_wren; idx increments only on mem_wren; no write and no advance while wdata_valid=0.
REQ-027 RUN load: one read issued per cycle, idx increments every cycle, mem_wren=0, wdata_ready=0.
REQ-028 Load response: rdata = mem_q, rdata_valid and rdata_idx are the issue-cycle flag and idx delayed one cycle (registered), so element k appears exactly 1 cycle after its address.
REQ-029 RUN -> DRAIN (load) or DONE (store) in the cycle the last element (idx==len-1) issues/writes.
REQ-030 DRAIN lasts exactly 1 cycle to deliver the final rdata_valid, then -> DONE.
REQ-031 DONE: done=1 for one cycle, -> IDLE; a new command is accepted no earlier than the following cycle.
REQ-032 abort in RUN or DRAIN: same-cycle mem_wren=0 and wdata_ready=0, no further reads issued, -> IDLE next cycle, no done pulse; any read already in flight is still delivered with rdata_valid; abort in IDLE/DONE ignored.
REQ-033 Outside RUN: mem_wren=0, wdata_ready=0; mem_addr holds base+idx.

Reset
REQ-034 rst_n low forces immediately: state=IDLE, idx=0, latched base/len/store=0, rdata_valid=0, rdata_idx=0, rdata=0, done=0, mem_wren=0, busy=0, cmd_ready=1 after release.
REQ-035 Reset mid-command abandons it without a done pulse and without further RAM writes.

Structure
REQ-036 Shared package mem_seq_pkg holds the state enum and ADDR_W/DATA_W defaults.
REQ-037 One sub-module, mem_addr_gen (idx counter, base adder, last-element compare), instantiated once.

Verification
REQ-038 Store base=0x10, len=4, wdata_valid constant 1 -> writes addr 0x10..0x13 on 4 consecutive cycles, done 1 cycle after last write.
REQ-039 Load base=0xFE, len=4 -> addresses 0xFE,0xFF,0x00,0x01; rdata_valid idx 0..3 each 1 cycle after its address; done after DRAIN.
REQ-040 Store len=3 with wdata_valid low for 2 cycles after element 0 -> exactly 3 writes, no duplicates, idx held during gap.
REQ-041 cmd_len=0 -> no RAM access, done pulse the cycle after accept.
REQ-042 Abort on load element 2 of 8 -> element 1 still delivered, no further rdata_valid, no done, IDLE next cycle.
REQ-043 rst_n low during store element 1 -> mem_wren low immediately, IDLE after release, next command executes normally.
